// File: rtl/hash_result_dispatcher.sv
// hash_result_dispatcher
//   Takes one bundle per handshake from the hash engine (a head address plus
//   ISSUE_WIDTH lanes of history candidates). Each lane is filtered by
//   validity and by match-window distance. The surviving candidates then go
//   out one per cycle as match requests. The final beat of each bundle
//   carries o_last and the bundle's delim flag. If no lane survives, the
//   bundle produces a single empty beat with o_cand=0 and o_last=1.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   i_valid / i_ready       bundle handshake
//   i_head_addr             address of lane 0 (lane k is head+k)
//   i_history_valid/_addr   per-lane candidate presence and address
//   i_meta_match_len/_can_ext  per-lane metadata copied to the beat
//   i_delim                 bundle ends a stream segment
//   o_valid / o_ready       request beat handshake
//   o_cand, o_lane          candidate flag and lane index
//   o_cur_addr, o_hist_addr current and candidate addresses
//   o_meta_match_len/_can_ext  lane metadata
//   o_last, o_delim         final-beat marker and the bundle delim on it
module hash_result_dispatcher #(
  parameter int ISSUE_WIDTH    = 8,
  parameter int ADDR_WIDTH     = 25,
  parameter int META_LEN_WIDTH = 5,
  parameter int WINDOW_LOG     = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_valid,
  output logic                                i_ready,
  input  logic [ADDR_WIDTH-1:0]               i_head_addr,
  input  logic [ISSUE_WIDTH-1:0]              i_history_valid,
  input  logic [ISSUE_WIDTH*ADDR_WIDTH-1:0]   i_history_addr,
  input  logic [ISSUE_WIDTH*META_LEN_WIDTH-1:0] i_meta_match_len,
  input  logic [ISSUE_WIDTH-1:0]              i_meta_match_can_ext,
  input  logic                                i_delim,
  output logic                                o_valid,
  input  logic                                o_ready,
  output logic                                o_cand,
  output logic [$clog2(ISSUE_WIDTH)-1:0]      o_lane,
  output logic [ADDR_WIDTH-1:0]               o_cur_addr,
  output logic [ADDR_WIDTH-1:0]               o_hist_addr,
  output logic [META_LEN_WIDTH-1:0]           o_meta_match_len,
  output logic                                o_meta_match_can_ext,
  output logic                                o_last,
  output logic                                o_delim
);

  localparam int LANE_W = $clog2(ISSUE_WIDTH);

  typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                              state_r, state_s;
  logic [ISSUE_WIDTH-1:0]              pend_r, pend_s;
  logic [ADDR_WIDTH-1:0]               head_r;
  logic [ISSUE_WIDTH*ADDR_WIDTH-1:0]   hist_r;
  logic [ISSUE_WIDTH*META_LEN_WIDTH-1:0] len_r;
  logic [ISSUE_WIDTH-1:0]              ext_r;
  logic                                delim_r;

  logic [ISSUE_WIDTH-1:0]              surv_s;
  logic [LANE_W-1:0]                   sel_s;
  logic                                last_s;
  logic                                load_s;
  logic                                fire_s;

  // Distance filter on the incoming bundle. The subtraction wraps modulo 2^ADDR_WIDTH.
  always_comb begin
    logic [ADDR_WIDTH-1:0] cur_v;
    logic [ADDR_WIDTH-1:0] dist_v;
    surv_s = '0;
    cur_v  = '0;
    dist_v = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      cur_v  = i_head_addr + ADDR_WIDTH'(k);
      dist_v = cur_v - i_history_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      // dist < 2^WINDOW_LOG means no bit at or above WINDOW_LOG is set.
      surv_s[k] = i_history_valid[k] && (dist_v != '0) &&
                  (dist_v[ADDR_WIDTH-1:WINDOW_LOG] == '0);
    end
  end

  // Select the lowest pending lane, and flag the last beat (at most one lane pending).
  always_comb begin
    sel_s = '0;
    for (int k = ISSUE_WIDTH - 1; k >= 0; k--) begin
      if (pend_r[k]) begin
        sel_s = LANE_W'(k);
      end else begin
        sel_s = sel_s;
      end
    end
    last_s = ((pend_r & (pend_r - ISSUE_WIDTH'(1))) == '0);
  end

  // Handshakes. A new bundle may load in the same cycle the last beat leaves.
  always_comb begin
    i_ready = (state_r == ST_EMPTY) || (o_ready && last_s);
    load_s  = i_valid && i_ready;
    fire_s  = (state_r == ST_HOLD) && o_ready;
  end

  // Next state and next pending mask.
  always_comb begin
    state_s = state_r;
    pend_s  = pend_r;
    if (load_s) begin
      state_s = ST_HOLD;
      pend_s  = surv_s;
    end else if (fire_s && last_s) begin
      state_s = ST_EMPTY;
      pend_s  = '0;
    end else if (fire_s) begin
      pend_s  = pend_r & ~(ISSUE_WIDTH'(1) << sel_s);
    end else begin
      state_s = state_r;
    end
  end

  // State and pending mask registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      pend_r  <= '0;
    end else begin
      state_r <= state_s;
      pend_r  <= pend_s;
    end
  end

  // Bundle payload holding register, captured on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_r  <= '0;
      hist_r  <= '0;
      len_r   <= '0;
      ext_r   <= '0;
      delim_r <= 1'b0;
    end else if (load_s) begin
      head_r  <= i_head_addr;
      hist_r  <= i_history_addr;
      len_r   <= i_meta_match_len;
      ext_r   <= i_meta_match_can_ext;
      delim_r <= i_delim;
    end else begin
      head_r  <= head_r;
    end
  end

  // Beat outputs, driven only from registers. They read zero when empty and on an empty beat.
  always_comb begin
    o_valid              = 1'b0;
    o_cand               = 1'b0;
    o_lane               = '0;
    o_cur_addr           = '0;
    o_hist_addr          = '0;
    o_meta_match_len     = '0;
    o_meta_match_can_ext = 1'b0;
    o_last               = 1'b0;
    o_delim              = 1'b0;
    if (state_r == ST_HOLD) begin
      o_valid = 1'b1;
      o_last  = last_s;
      o_delim = last_s & delim_r;
      if (pend_r != '0) begin
        o_cand               = 1'b1;
        o_lane               = sel_s;
        o_cur_addr           = head_r + ADDR_WIDTH'(sel_s);
        o_hist_addr          = hist_r[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
        o_meta_match_len     = len_r[sel_s*META_LEN_WIDTH +: META_LEN_WIDTH];
        o_meta_match_can_ext = ext_r[sel_s];
      end else begin
        o_cand = 1'b0;
      end
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule
